// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: shares the register-file write port between the ALU (req0)
// and the load unit (req1). Fixed priority for req0, with a starvation guard that
// hands one grant to req1 after it has been refused MAX_WAIT cycles in a row.
// The write port is registered, and writes to x0 are accepted but suppressed.
module regfile_wb_arbiter #(
    parameter int unsigned MAX_WAIT = 3,
    parameter int unsigned XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_valid,
    input  logic [4:0]      req0_addr,
    input  logic [XLEN-1:0] req0_data,
    output logic            req0_ready,
    input  logic            req1_valid,
    input  logic [4:0]      req1_addr,
    input  logic [XLEN-1:0] req1_data,
    output logic            req1_ready,
    output logic            rf_we,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic            starve_flag
);

    localparam int unsigned AW = 5;
    localparam int unsigned CW = 4;
    localparam logic [CW-1:0] WAIT_LIMIT = CW'(MAX_WAIT);

    // Grants for the current cycle
    logic gnt0_c;
    logic gnt1_c;

    // Starvation tracking state
    logic [CW-1:0] wait_cnt_q;
    logic [CW-1:0] wait_cnt_d;
    logic          starve_flag_q;
    logic          starve_flag_d;

    // Registered write port
    logic            rf_we_q;
    logic            rf_we_d;
    logic [AW-1:0]   rf_waddr_q;
    logic [AW-1:0]   rf_waddr_d;
    logic [XLEN-1:0] rf_wdata_q;
    logic [XLEN-1:0] rf_wdata_d;

    // Arbitration: req0 wins contention unless the starvation override is armed.
    // Nothing is granted while reset is held.
    always_comb begin
        gnt0_c = 1'b0;
        gnt1_c = 1'b0;
        if (!rst) begin
            if (req1_valid && (!req0_valid || starve_flag_q)) begin
                gnt1_c = 1'b1;
            end else if (req0_valid) begin
                gnt0_c = 1'b1;
            end
        end
    end

    assign req0_ready = gnt0_c;
    assign req1_ready = gnt1_c;

    // Refusal counter: counts consecutive cycles req1 waits, clears on grant or idle
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!req1_valid || gnt1_c) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q < WAIT_LIMIT) begin
            wait_cnt_d = wait_cnt_q + CW'(1);
        end
        starve_flag_d = (wait_cnt_d == WAIT_LIMIT);
    end

    // Write-port next state: capture the granted request; x0 writes keep we low
    always_comb begin
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        if (gnt1_c) begin
            rf_we_d    = (req1_addr != '0);
            rf_waddr_d = req1_addr;
            rf_wdata_d = req1_data;
        end else if (gnt0_c) begin
            rf_we_d    = (req0_addr != '0);
            rf_waddr_d = req0_addr;
            rf_wdata_d = req0_data;
        end
    end

    // State registers; reset discards any in-flight write immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_q    <= '0;
            starve_flag_q <= 1'b0;
            rf_we_q       <= 1'b0;
            rf_waddr_q    <= '0;
            rf_wdata_q    <= '0;
        end else begin
            wait_cnt_q    <= wait_cnt_d;
            starve_flag_q <= starve_flag_d;
            rf_we_q       <= rf_we_d;
            rf_waddr_q    <= rf_waddr_d;
            rf_wdata_q    <= rf_wdata_d;
        end
    end

    assign rf_we       = rf_we_q;
    assign rf_waddr    = rf_waddr_q;
    assign rf_wdata    = rf_wdata_q;
    assign starve_flag = starve_flag_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: expected write-port values are queued when a
// request is driven and compared one cycle later when the registered port updates.
module tb_regfile_wb_arbiter;

    localparam int unsigned XLEN = 32;

    logic            clk;
    logic            rst;
    logic            req0_valid;
    logic [4:0]      req0_addr;
    logic [XLEN-1:0] req0_data;
    logic            req0_ready;
    logic            req1_valid;
    logic [4:0]      req1_addr;
    logic [XLEN-1:0] req1_data;
    logic            req1_ready;
    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic            starve_flag;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic            we;
        logic [4:0]      addr;
        logic [XLEN-1:0] data;
    } wb_t;

    wb_t             sbq[$];
    logic [4:0]      hold_a;
    logic [XLEN-1:0] hold_d;

    regfile_wb_arbiter #(.MAX_WAIT(3), .XLEN(XLEN)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .starve_flag(starve_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

    task automatic drive(input logic v0, input logic [4:0] a0, input logic [XLEN-1:0] d0,
                         input logic v1, input logic [4:0] a1, input logic [XLEN-1:0] d1);
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
    endtask

    // Queue the write-port value expected after the next rising edge
    function automatic void sb_expect(input logic xfer, input logic [4:0] a, input logic [XLEN-1:0] d);
        wb_t e;
        if (xfer) begin
            hold_a = a;
            hold_d = d;
        end
        e.we   = xfer && (a != 5'd0);
        e.addr = hold_a;
        e.data = hold_d;
        sbq.push_back(e);
    endfunction

    // One idle cycle with no requests; leaves the counter cleared
    task automatic idle();
        drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        wb_t e;
        rst = 1'b1;
        drive(1'b1, 5'd3, 32'h0000_0033, 1'b1, 5'd4, 32'h0000_0044);
        #2;
        checks++;
        if ({rf_we, rf_waddr, rf_wdata} !== {1'b0, 5'd0, 32'd0}) begin
            errors++;
            $display("FAIL reset_port got=%b/%0d/%h exp=0/0/0", rf_we, rf_waddr, rf_wdata);
        end
        checks++;
        if ({req0_ready, req1_ready, starve_flag} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ready got=%b%b%b exp=000", req0_ready, req1_ready, starve_flag);
        end
        @(posedge clk); #1;
        checks++;
        if (rf_we !== 1'b0) begin
            errors++;
            $display("FAIL reset_hold_we got=%b exp=0", rf_we);
        end
        rst = 1'b0;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++;
            $display("FAIL reset_first_grant got=%b%b exp=10", req0_ready, req1_ready);
        end
        sb_expect(1'b1, 5'd3, 32'h0000_0033);
        @(posedge clk); #1;
        e = sbq.pop_front();
        checks++;
        if ({rf_we, rf_waddr, rf_wdata} !== {e.we, e.addr, e.data}) begin
            errors++;
            $display("FAIL reset_first_write got=%b/%0d/%h exp=%b/%0d/%h", rf_we, rf_waddr, rf_wdata, e.we, e.addr, e.data);
        end
        idle();
    endtask

    task automatic test_single();
        wb_t e;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) drive(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, '0);
            else        drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
            #1;
            checks++;
            if ({req0_ready, req1_ready} !== {(k == 0), 1'b0}) begin
                errors++;
                $display("FAIL single_ready cyc=%0d got=%b%b exp=%b0", k, req0_ready, req1_ready, (k == 0));
            end
            sb_expect(k == 0, 5'd5, 32'hDEAD_BEEF);
            @(posedge clk); #1;
            e = sbq.pop_front();
            checks++;
            if ({rf_we, rf_waddr, rf_wdata} !== {e.we, e.addr, e.data}) begin
                errors++;
                $display("FAIL single_write cyc=%0d got=%b/%0d/%h exp=%b/%0d/%h", k, rf_we, rf_waddr, rf_wdata, e.we, e.addr, e.data);
            end
        end
    endtask

    task automatic test_contention();
        wb_t e;
        logic [4:0] exp_g1;
        exp_g1 = 5'b01000;
        idle();
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 5'd1, 32'hA000_0000 + 32'(k), 1'b1, 5'd2, 32'hB000_0000 + 32'(k));
            #1;
            checks++;
            if ({req0_ready, req1_ready, starve_flag} !== {~exp_g1[k], exp_g1[k], exp_g1[k]}) begin
                errors++;
                $display("FAIL contention_grant cyc=%0d got=r0%b r1%b sf%b exp=r0%b r1%b sf%b",
                         k, req0_ready, req1_ready, starve_flag, ~exp_g1[k], exp_g1[k], exp_g1[k]);
            end
            if (exp_g1[k]) sb_expect(1'b1, 5'd2, 32'hB000_0000 + 32'(k));
            else           sb_expect(1'b1, 5'd1, 32'hA000_0000 + 32'(k));
            @(posedge clk); #1;
            e = sbq.pop_front();
            checks++;
            if ({rf_we, rf_waddr, rf_wdata} !== {e.we, e.addr, e.data}) begin
                errors++;
                $display("FAIL contention_write cyc=%0d got=%b/%0d/%h exp=%b/%0d/%h", k, rf_we, rf_waddr, rf_wdata, e.we, e.addr, e.data);
            end
        end
        idle();
    endtask

    task automatic test_x0_filter();
        wb_t e;
        drive(1'b0, 5'd0, '0, 1'b1, 5'd0, 32'h1234_5678);
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            errors++;
            $display("FAIL x0_ready got=%b%b exp=01", req0_ready, req1_ready);
        end
        sb_expect(1'b1, 5'd0, 32'h1234_5678);
        @(posedge clk); #1;
        e = sbq.pop_front();
        checks++;
        if ({rf_we, rf_waddr, rf_wdata} !== {e.we, e.addr, e.data}) begin
            errors++;
            $display("FAIL x0_write got=%b/%0d/%h exp=%b/%0d/%h", rf_we, rf_waddr, rf_wdata, e.we, e.addr, e.data);
        end
        idle();
    endtask

    task automatic test_counter_clear();
        wb_t e;
        logic [6:0] v1_pat;
        logic [6:0] exp_g1;
        v1_pat = 7'b1111011;
        exp_g1 = 7'b1000000;
        for (int k = 0; k < 7; k++) begin
            drive(1'b1, 5'd7, 32'h7000_0000 + 32'(k), v1_pat[k], 5'd9, 32'h9000_0000 + 32'(k));
            #1;
            checks++;
            if ({req0_ready, req1_ready, starve_flag} !== {~exp_g1[k], exp_g1[k], exp_g1[k]}) begin
                errors++;
                $display("FAIL clear_grant cyc=%0d got=r0%b r1%b sf%b exp=r0%b r1%b sf%b",
                         k, req0_ready, req1_ready, starve_flag, ~exp_g1[k], exp_g1[k], exp_g1[k]);
            end
            if (exp_g1[k]) sb_expect(1'b1, 5'd9, 32'h9000_0000 + 32'(k));
            else           sb_expect(1'b1, 5'd7, 32'h7000_0000 + 32'(k));
            @(posedge clk); #1;
            e = sbq.pop_front();
            checks++;
            if ({rf_we, rf_waddr, rf_wdata} !== {e.we, e.addr, e.data}) begin
                errors++;
                $display("FAIL clear_write cyc=%0d got=%b/%0d/%h exp=%b/%0d/%h", k, rf_we, rf_waddr, rf_wdata, e.we, e.addr, e.data);
            end
        end
        idle();
    endtask

    task automatic test_back_to_back();
        wb_t e;
        int   cnt;
        logic v0, v1, g0, g1, sf;
        logic [4:0] a0, a1;
        logic [XLEN-1:0] d0, d1;
        cnt = 0;
        for (int k = 0; k < 60; k++) begin
            v0 = ($urandom_range(0, 3) != 0);
            v1 = ($urandom_range(0, 3) != 0);
            a0 = 5'($urandom_range(0, 31));
            a1 = 5'($urandom_range(0, 31));
            d0 = $urandom;
            d1 = $urandom;
            drive(v0, a0, d0, v1, a1, d1);
            sf = (cnt == 3);
            g1 = v1 && (!v0 || sf);
            g0 = v0 && !g1;
            #1;
            checks++;
            if ({req0_ready, req1_ready, starve_flag} !== {g0, g1, sf}) begin
                errors++;
                $display("FAIL b2b_grant cyc=%0d got=r0%b r1%b sf%b exp=r0%b r1%b sf%b",
                         k, req0_ready, req1_ready, starve_flag, g0, g1, sf);
            end
            if (g1)      sb_expect(1'b1, a1, d1);
            else if (g0) sb_expect(1'b1, a0, d0);
            else         sb_expect(1'b0, 5'd0, '0);
            if (!v1 || g1) cnt = 0;
            else if (cnt < 3) cnt++;
            @(posedge clk); #1;
            e = sbq.pop_front();
            checks++;
            if ({rf_we, rf_waddr, rf_wdata} !== {e.we, e.addr, e.data}) begin
                errors++;
                $display("FAIL b2b_write cyc=%0d got=%b/%0d/%h exp=%b/%0d/%h", k, rf_we, rf_waddr, rf_wdata, e.we, e.addr, e.data);
            end
        end
        idle();
    endtask

    task automatic test_async_reset();
        wb_t e;
        drive(1'b1, 5'd10, 32'hCAFE_0010, 1'b0, 5'd0, '0);
        #1;
        sb_expect(1'b1, 5'd10, 32'hCAFE_0010);
        @(posedge clk); #1;
        e = sbq.pop_front();
        checks++;
        if ({rf_we, rf_waddr, rf_wdata} !== {e.we, e.addr, e.data}) begin
            errors++;
            $display("FAIL async_pre_write got=%b/%0d/%h exp=%b/%0d/%h", rf_we, rf_waddr, rf_wdata, e.we, e.addr, e.data);
        end
        // A second write is granted this cycle but reset lands before its edge
        drive(1'b1, 5'd11, 32'hCAFE_0011, 1'b1, 5'd12, 32'hCAFE_0012);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({rf_we, rf_waddr, rf_wdata, starve_flag} !== {1'b0, 5'd0, 32'd0, 1'b0}) begin
            errors++;
            $display("FAIL async_drop got=%b/%0d/%h sf%b exp=0/0/0 sf0", rf_we, rf_waddr, rf_wdata, starve_flag);
        end
        checks++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            errors++;
            $display("FAIL async_ready got=%b%b exp=00", req0_ready, req1_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (rf_we !== 1'b0) begin
            errors++;
            $display("FAIL async_lost got=%b exp=0", rf_we);
        end
        rst = 1'b0;
        hold_a = 5'd0;
        hold_d = '0;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++;
            $display("FAIL async_regrant got=%b%b exp=10", req0_ready, req1_ready);
        end
        sb_expect(1'b1, 5'd11, 32'hCAFE_0011);
        @(posedge clk); #1;
        e = sbq.pop_front();
        checks++;
        if ({rf_we, rf_waddr, rf_wdata} !== {e.we, e.addr, e.data}) begin
            errors++;
            $display("FAIL async_post_write got=%b/%0d/%h exp=%b/%0d/%h", rf_we, rf_waddr, rf_wdata, e.we, e.addr, e.data);
        end
        idle();
    endtask

    initial begin
        rst    = 1'b1;
        hold_a = 5'd0;
        hold_d = '0;
        drive(1'b0, 5'd0, '0, 1'b0, 5'd0, '0);
        test_reset();
        test_single();
        test_contention();
        test_x0_filter();
        test_counter_clear();
        test_back_to_back();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
